// File: rtl/icache_fetch_pkg.sv
// rtl/icache_fetch_pkg.sv - shared definitions and local types for icache_fetch
//
// Purpose: shared definitions used by the fetch cache and its callers
// (address/word/status widths, memory-controller status codes, enable
// levels) plus the cache's local FSM encoding and an address helper.
// Ports: none (package).
// Configuration: macro ICACHE_FETCH_EN selects whether the line arrays exist.

`ifndef ICACHE_FETCH_SHARED_DEFS
`define ICACHE_FETCH_SHARED_DEFS
`define RAMAddrLen   32
`define RegLen       32
`define MCtrlStatLen 2
`define Free         2'b00
`define Busy         2'b01
`define IHandled     2'b10
`define DHandled     2'b11
`define Enable       1'b1
`define Disable      1'b0
`endif

package icache_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte address of the instruction word containing addr.
  function automatic logic [`RAMAddrLen-1:0] word_align(input logic [`RAMAddrLen-1:0] addr);
    return {addr[`RAMAddrLen-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage for icache_fetch
//
// Purpose: line storage with one combinational read port and one synchronous
// write port; valid bits clear asynchronously on rst.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_index_i          line selected for lookup
//   rd_valid_o/rd_tag_o/rd_data_o  contents of the selected line
//   wr_en_i             write the line at wr_index_i on the next rising edge
//   wr_index_i/wr_tag_i/wr_data_i  fill contents
// Configuration: without ICACHE_FETCH_EN no storage exists and every lookup
// reports an invalid line.

module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = `RAMAddrLen - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [`RegLen-1:0]    rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [`RegLen-1:0]    wr_data_i
);

`ifdef ICACHE_FETCH_EN
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [`RegLen-1:0]  data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only ever read qualified by valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];
`else
  logic unused_array_inputs;
  assign unused_array_inputs = ^{clk, rst, rd_index_i, wr_en_i, wr_index_i, wr_tag_i, wr_data_i};

  assign rd_valid_o = 1'b0;
  assign rd_tag_o   = '0;
  assign rd_data_o  = '0;
`endif

endmodule

// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped instruction fetch cache in front of the memory controller
//
// Purpose: serves instruction fetches from a one-word-per-line direct-mapped
// cache; misses are forwarded to the memory controller and the returned word
// both fills the line and answers the fetch.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   fetch_req_i/fetch_addr_i     fetch request and byte address (bits [1:0] ignored)
//   fetch_flush_i                abandon the current request
//   fetch_hit_o/fetch_inst_o     one-cycle result pulse and instruction word
//   mc_req_en_o/mc_req_addr_o    instruction read request to the memory controller
//   mc_data_i/mc_handled_addr_i/mc_stat_i  memory controller completion
// Configuration: macro ICACHE_FETCH_EN enables the line arrays; when undefined
// every request goes to the memory controller.

module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req_i,
  input  logic [`RAMAddrLen-1:0]   fetch_addr_i,
  input  logic                     fetch_flush_i,
  output logic                     fetch_hit_o,
  output logic [`RegLen-1:0]       fetch_inst_o,
  output logic                     mc_req_en_o,
  output logic [`RAMAddrLen-1:0]   mc_req_addr_o,
  input  logic [`RegLen-1:0]       mc_data_i,
  input  logic [`RAMAddrLen-1:0]   mc_handled_addr_i,
  input  logic [`MCtrlStatLen-1:0] mc_stat_i
);

  localparam int TAG_BITS = `RAMAddrLen - INDEX_BITS - 2;

  state_e                 state_q, state_d;
  logic [`RAMAddrLen-1:0] miss_addr_q, miss_addr_d;
  logic                   fetch_hit_q, fetch_hit_d;
  logic [`RegLen-1:0]     fetch_inst_q, fetch_inst_d;

  logic [INDEX_BITS-1:0]  lookup_index;
  logic [TAG_BITS-1:0]    lookup_tag;
  logic                   rd_valid;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [`RegLen-1:0]     rd_data;
  logic                   lookup_hit;
  logic                   mc_done;
  logic                   fill_en;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^fetch_addr_i[1:0];

  assign lookup_index = fetch_addr_i[INDEX_BITS+1:2];
  assign lookup_tag   = fetch_addr_i[`RAMAddrLen-1:INDEX_BITS+2];
  assign lookup_hit   = rd_valid && (rd_tag == lookup_tag);

  // Only an instruction completion for the exact outstanding word ends a miss;
  // stale or data-side completions are left for their own owners.
  assign mc_done = (mc_stat_i == `IHandled) && (mc_handled_addr_i == miss_addr_q);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (lookup_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_en),
    .wr_index_i (miss_addr_q[INDEX_BITS+1:2]),
    .wr_tag_i   (miss_addr_q[`RAMAddrLen-1:INDEX_BITS+2]),
    .wr_data_i  (mc_data_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      fetch_hit_q  <= 1'b0;
      fetch_inst_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      fetch_hit_q  <= fetch_hit_d;
      fetch_inst_q <= fetch_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    fetch_hit_d  = 1'b0;
    fetch_inst_d = fetch_inst_q;
    fill_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A flush cycle accepts nothing; the redirected request is looked up
        // in the following cycle.
        if (fetch_req_i && !fetch_flush_i) begin
          if (lookup_hit) begin
            fetch_hit_d  = 1'b1;
            fetch_inst_d = rd_data;
          end else begin
            miss_addr_d = word_align(fetch_addr_i);
            state_d     = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        // Flush wins over a same-cycle completion: no fill, no result.
        if (fetch_flush_i) begin
          state_d = ST_IDLE;
        end else if (mc_done) begin
          fill_en      = 1'b1;
          fetch_inst_d = mc_data_i;
          fetch_hit_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mc_req_en_o   = (state_q == ST_MISS) ? `Enable : `Disable;
  assign mc_req_addr_o = miss_addr_q;
  assign fetch_hit_o   = fetch_hit_q;
  assign fetch_inst_o  = fetch_inst_q;

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - directed self-checking bench for icache_fetch

module tb_icache_fetch;

  localparam logic [1:0] ST_FREE  = 2'b00;
  localparam logic [1:0] ST_IHND  = 2'b10;
  localparam logic [1:0] ST_DHND  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_hit;
  logic [31:0] fetch_inst;
  logic        mc_req_en;
  logic [31:0] mc_req_addr;
  logic [31:0] mc_data;
  logic [31:0] mc_handled_addr;
  logic [1:0]  mc_stat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_fetch #(.INDEX_BITS(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_req_i       (fetch_req),
    .fetch_addr_i      (fetch_addr),
    .fetch_flush_i     (fetch_flush),
    .fetch_hit_o       (fetch_hit),
    .fetch_inst_o      (fetch_inst),
    .mc_req_en_o       (mc_req_en),
    .mc_req_addr_o     (mc_req_addr),
    .mc_data_i         (mc_data),
    .mc_handled_addr_i (mc_handled_addr),
    .mc_stat_i         (mc_stat)
  );

  // Drives one fetch and plays the memory controller: answers IHandled on the
  // resp_after-th cycle of mc_req_en. Observes 20 cycles, then stops.
  task automatic run_fetch(input logic [31:0] addr, input int resp_after, input logic [31:0] data,
                           output int en_cycles, output int hits, output int hit_at,
                           output logic [31:0] inst, output int addr_bad);
    logic [31:0] aligned;
    aligned   = {addr[31:2], 2'b00};
    en_cycles = 0; hits = 0; hit_at = 0; inst = '0; addr_bad = 0;
    fetch_addr = addr;
    fetch_req  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      mc_stat = ST_FREE;
      if (mc_req_en) begin
        en_cycles++;
        if (mc_req_addr !== aligned) addr_bad++;
        if (en_cycles == resp_after) begin
          mc_stat = ST_IHND; mc_handled_addr = aligned; mc_data = data;
        end
      end
      if (fetch_hit) begin
        hits++;
        if (hits == 1) begin hit_at = i; inst = fetch_inst; end
        fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
    mc_data = '0; mc_handled_addr = '0; mc_stat = ST_FREE;
    repeat (2) @(negedge clk);
    checks++; if (fetch_hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", fetch_hit); end
    checks++; if (fetch_inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h expected 0", fetch_inst); end
    checks++; if (mc_req_en !== 1'b0) begin failures++; $display("FAIL reset_req_en: got %b expected 0", mc_req_en); end
    checks++; if (mc_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr: got %h expected 0", mc_req_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    int en, hits, at, bad; logic [31:0] inst;
    run_fetch(32'h0000_1004, 6, 32'h0000_0013, en, hits, at, inst, bad);
    checks++; if (en !== 6) begin failures++; $display("FAIL cold_req_cycles: got %0d expected 6", en); end
    checks++; if (hits !== 1) begin failures++; $display("FAIL cold_hits: got %0d expected 1", hits); end
    checks++; if (at !== 7) begin failures++; $display("FAIL cold_latency: got %0d expected 7", at); end
    checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL cold_inst: got %h expected 00000013", inst); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL cold_req_addr: %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_hit();
    int en, hits, at, bad; logic [31:0] inst;
    run_fetch(32'h0000_1004, 2, 32'h0000_0013, en, hits, at, inst, bad);
`ifdef ICACHE_FETCH_EN
    checks++; if (en !== 0) begin failures++; $display("FAIL hit_req_cycles: got %0d expected 0", en); end
    checks++; if (at !== 1) begin failures++; $display("FAIL hit_latency: got %0d expected 1", at); end
`else
    checks++; if (en !== 2) begin failures++; $display("FAIL hit_req_cycles: got %0d expected 2", en); end
    checks++; if (at !== 3) begin failures++; $display("FAIL hit_latency: got %0d expected 3", at); end
`endif
    checks++; if (hits !== 1) begin failures++; $display("FAIL hit_hits: got %0d expected 1", hits); end
    checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL hit_inst: got %h expected 00000013", inst); end
  endtask

  task automatic test_conflict();
    int en, hits, at, bad; logic [31:0] inst;
    run_fetch(32'h0000_1104, 3, 32'h0010_0093, en, hits, at, inst, bad);
    checks++; if (en !== 3) begin failures++; $display("FAIL conf1_req_cycles: got %0d expected 3", en); end
    checks++; if (inst !== 32'h0010_0093 || hits !== 1) begin failures++; $display("FAIL conf1_result: got %h/%0d expected 00100093/1", inst, hits); end
    run_fetch(32'h0000_1004, 2, 32'h0000_0013, en, hits, at, inst, bad);
    checks++; if (en !== 2) begin failures++; $display("FAIL conf2_req_cycles: got %0d expected 2", en); end
    checks++; if (inst !== 32'h0000_0013 || at !== 3) begin failures++; $display("FAIL conf2_result: got %h at %0d expected 00000013 at 3", inst, at); end
    // Low address bits are ignored: 0x1106 requests word 0x1104.
    run_fetch(32'h0000_1106, 1, 32'h0020_0113, en, hits, at, inst, bad);
    checks++; if (en !== 1 || bad !== 0) begin failures++; $display("FAIL conf3_req: got %0d cycles %0d bad expected 1/0", en, bad); end
    checks++; if (inst !== 32'h0020_0113 || at !== 2) begin failures++; $display("FAIL conf3_result: got %h at %0d expected 00200113 at 2", inst, at); end
  endtask

  task automatic test_flush_miss();
    int en, hits, at, bad, en_after, hit_cnt; logic [31:0] inst;
    en = 0; hit_cnt = 0; en_after = 0;
    fetch_addr = 32'h0000_2000; fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mc_req_en) en++;
      if (fetch_hit) hit_cnt++;
    end
    fetch_flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    fetch_flush = 1'b0;
    checks++; if (en !== 3) begin failures++; $display("FAIL flush_req_cycles: got %0d expected 3", en); end
    checks++; if (mc_req_en !== 1'b0) begin failures++; $display("FAIL flush_req_drop: got %b expected 0", mc_req_en); end
    mc_stat = ST_IHND; mc_handled_addr = 32'h0000_2000; mc_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mc_stat = ST_FREE;
      if (fetch_hit) hit_cnt++;
      if (mc_req_en) en_after++;
    end
    checks++; if (hit_cnt !== 0 || en_after !== 0) begin failures++; $display("FAIL flush_no_hit: got %0d hits %0d req expected 0/0", hit_cnt, en_after); end
    run_fetch(32'h0000_2000, 2, 32'h0000_0093, en, hits, at, inst, bad);
    checks++; if (en !== 2 || inst !== 32'h0000_0093) begin failures++; $display("FAIL flush_refetch: got %0d cycles %h expected 2/00000093", en, inst); end

    // Flush in the same cycle as the matching completion.
    hit_cnt = 0;
    fetch_addr = 32'h0000_2400; fetch_req = 1'b1;
    repeat (2) @(negedge clk);
    fetch_flush = 1'b1; fetch_req = 1'b0;
    mc_stat = ST_IHND; mc_handled_addr = 32'h0000_2400; mc_data = 32'hDEAD_BEEF;
    @(negedge clk);
    fetch_flush = 1'b0; mc_stat = ST_FREE;
    for (int i = 0; i < 3; i++) begin
      if (fetch_hit) hit_cnt++;
      @(negedge clk);
    end
    checks++; if (hit_cnt !== 0) begin failures++; $display("FAIL flush_same_cycle_hit: got %0d expected 0", hit_cnt); end
    run_fetch(32'h0000_2400, 1, 32'h0000_0193, en, hits, at, inst, bad);
    checks++; if (en !== 1 || inst !== 32'h0000_0193) begin failures++; $display("FAIL flush_same_cycle_refetch: got %0d cycles %h expected 1/00000193", en, inst); end
  endtask

  task automatic test_stale_resp();
    int en, hit_cnt, at;
    logic [31:0] inst;
    en = 0; hit_cnt = 0; at = 0; inst = '0;
    fetch_addr = 32'h0000_3000; fetch_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      mc_stat = ST_FREE;
      if (mc_req_en) begin
        en++;
        case (en)
          2: begin mc_stat = ST_IHND; mc_handled_addr = 32'h0000_2FFC; mc_data = 32'h1111_1111; end
          3: begin mc_stat = ST_DHND; mc_handled_addr = 32'h0000_3000; mc_data = 32'h2222_2222; end
          5: begin mc_stat = ST_IHND; mc_handled_addr = 32'h0000_3000; mc_data = 32'h0000_0513; end
          default: ;
        endcase
      end
      if (fetch_hit) begin
        hit_cnt++;
        if (hit_cnt == 1) begin at = i; inst = fetch_inst; end
        fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    checks++; if (en !== 5) begin failures++; $display("FAIL stale_req_cycles: got %0d expected 5", en); end
    checks++; if (hit_cnt !== 1 || at !== 6) begin failures++; $display("FAIL stale_hit: got %0d at %0d expected 1 at 6", hit_cnt, at); end
    checks++; if (inst !== 32'h0000_0513) begin failures++; $display("FAIL stale_inst: got %h expected 00000513", inst); end
  endtask

  task automatic test_async_reset();
    int en, hits, at, bad, hit_cnt; logic [31:0] inst;
    hit_cnt = 0; en = 0;
    fetch_addr = 32'h0000_4000; fetch_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mc_req_en !== 1'b1) begin failures++; $display("FAIL areset_pre_req: got %b expected 1", mc_req_en); end
    #2 rst = 1'b1; fetch_req = 1'b0;
    #1;
    checks++; if (mc_req_en !== 1'b0) begin failures++; $display("FAIL areset_req_en: got %b expected 0", mc_req_en); end
    checks++; if (mc_req_addr !== 32'h0) begin failures++; $display("FAIL areset_req_addr: got %h expected 0", mc_req_addr); end
    checks++; if (fetch_inst !== 32'h0 || fetch_hit !== 1'b0) begin failures++; $display("FAIL areset_outputs: got %h/%b expected 0/0", fetch_inst, fetch_hit); end
    @(negedge clk);
    rst = 1'b0;
    mc_stat = ST_IHND; mc_handled_addr = 32'h0000_4000; mc_data = 32'h3333_3333;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mc_stat = ST_FREE;
      if (fetch_hit) hit_cnt++;
      if (mc_req_en) en++;
    end
    checks++; if (hit_cnt !== 0 || en !== 0) begin failures++; $display("FAIL areset_late_resp: got %0d hits %0d req expected 0/0", hit_cnt, en); end
    // 0x1104 was filled before the reset; valid bits must have cleared.
    run_fetch(32'h0000_1104, 2, 32'h0020_0113, en, hits, at, inst, bad);
    checks++; if (en !== 2 || at !== 3) begin failures++; $display("FAIL areset_valid_clear: got %0d cycles hit at %0d expected 2/3", en, at); end
  endtask

  task automatic test_back_to_back();
    int en, hits, at, bad; logic [31:0] inst;
    run_fetch(32'h0000_1104, 2, 32'h0020_0113, en, hits, at, inst, bad);
`ifdef ICACHE_FETCH_EN
    checks++; if (en !== 0 || at !== 1) begin failures++; $display("FAIL b2b_first: got %0d cycles hit at %0d expected 0/1", en, at); end
`else
    checks++; if (en !== 2 || at !== 3) begin failures++; $display("FAIL b2b_first: got %0d cycles hit at %0d expected 2/3", en, at); end
`endif
    run_fetch(32'h0000_0008, 4, 32'h0040_0213, en, hits, at, inst, bad);
    checks++; if (en !== 4 || hits !== 1 || inst !== 32'h0040_0213) begin failures++; $display("FAIL b2b_second: got %0d cycles %0d hits %h expected 4/1/00400213", en, hits, inst); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_miss();
    test_stale_resp();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
